snake_input_ctrl: RTL and testbench

Upstream stage of the snake game core. Conditions the raw BTN[3:0] pushbuttons with a synchronizer and a per-button debouncer, and filters out illegal turns. Generates the speed-selected move tick from SW[2:0]. Hands the game core a registered direction and a one-cycle move strobe, so the core only updates the head position on move_tick.

---
 rtl/snake_input_ctrl.sv | 178 +++++++++++++++++
 tb/tb_snake_input_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: upstream input stage of the snake game core.
// Synchronizes and debounces the four direction buttons, filters illegal
// turns, and produces the speed-selected move tick together with the
// registered direction the core should use on that tick.
// Optional feature macro: SNAKE_TURN_QUEUE_EN (2-entry turn FIFO instead
// of a single overwriting pending-turn register).
module snake_input_ctrl #(
    parameter int         DEBOUNCE_CYCLES  = 1000000,
    parameter int         BASE_TICK_CYCLES = 50000000,
    parameter logic [1:0] RESET_DIR        = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] BTN,
    input  logic [2:0] SW,
    input  logic       halt,
    output logic [1:0] dir,
    output logic       move_tick,
    output logic [3:0] btn_pulse,
    output logic [1:0] pending_cnt
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(BASE_TICK_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] BASE_TC  = TW'(BASE_TICK_CYCLES);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    stable;
    logic [DW-1:0] deb_cnt [4];

    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] period;
    logic [TW-1:0] period_last;
    logic          tick_hit;

    logic [1:0]    q0;
    logic [1:0]    q1;
    logic [1:0]    q_cnt;

    logic          pop;
    logic [1:0]    dir_next;
    logic [1:0]    q0_ap;
    logic [1:0]    q_cnt_ap;
    logic          have_cand;
    logic [1:0]    cand;
    logic [1:0]    ref_dir;
    logic          legal;
    logic [1:0]    q0_n;
    logic [1:0]    q1_n;
    logic [1:0]    q_cnt_n;

    assign pending_cnt = q_cnt;

    // Two-flop synchronizer bringing the raw buttons into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 4'd0;
            sync2 <= 4'd0;
        end else begin
            sync1 <= BTN;
            sync2 <= sync1;
        end
    end

    // Per-button debouncer: accept a new level after DEBOUNCE_CYCLES differing cycles, pulse on accepted presses.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable    <= 4'd0;
            btn_pulse <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                btn_pulse[i] <= 1'b0;
                if (sync2[i] != stable[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        stable[i]    <= sync2[i];
                        deb_cnt[i]   <= '0;
                        btn_pulse[i] <= sync2[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Next-state logic: tick detection, pop on tick, then legality check and push of the selected press.
    always_comb begin
        period      = BASE_TC >> SW;
        period_last = period - TW'(1);
        tick_hit    = !halt && (tick_cnt >= period_last);

        pop      = tick_hit && (q_cnt != 2'd0);
        dir_next = pop ? q0 : dir;
        q0_ap    = pop ? q1 : q0;
        q_cnt_ap = pop ? (q_cnt - 2'd1) : q_cnt;

        have_cand = !halt && (btn_pulse != 4'd0);
        if (btn_pulse[0]) begin
            cand = 2'd0;
        end else if (btn_pulse[1]) begin
            cand = 2'd1;
        end else if (btn_pulse[2]) begin
            cand = 2'd2;
        end else begin
            cand = 2'd3;
        end

`ifdef SNAKE_TURN_QUEUE_EN
        if (q_cnt_ap == 2'd0) begin
            ref_dir = dir_next;
        end else if (q_cnt_ap == 2'd1) begin
            ref_dir = q0_ap;
        end else begin
            ref_dir = q1;
        end
`else
        ref_dir = dir_next;
`endif

        legal = have_cand && (cand != ref_dir) &&
                !((cand[1] == ref_dir[1]) && (cand[0] != ref_dir[0]));

        q0_n    = q0_ap;
        q1_n    = q1;
        q_cnt_n = q_cnt_ap;

`ifdef SNAKE_TURN_QUEUE_EN
        if (legal && (q_cnt_ap != 2'd2)) begin
            if (q_cnt_ap == 2'd0) begin
                q0_n = cand;
            end else begin
                q1_n = cand;
            end
            q_cnt_n = q_cnt_ap + 2'd1;
        end
`else
        if (legal) begin
            q0_n    = cand;
            q_cnt_n = 2'd1;
        end
`endif
    end

    // Move-tick counter, registered direction and pending-turn storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            move_tick <= 1'b0;
            dir       <= RESET_DIR;
            q0        <= 2'd0;
            q1        <= 2'd0;
            q_cnt     <= 2'd0;
        end else begin
            if (halt) begin
                tick_cnt  <= '0;
                move_tick <= 1'b0;
            end else if (tick_hit) begin
                tick_cnt  <= '0;
                move_tick <= 1'b1;
            end else begin
                tick_cnt  <= tick_cnt + TW'(1);
                move_tick <= 1'b0;
            end
            dir   <= dir_next;
            q0    <= q0_n;
            q1    <= q1_n;
            q_cnt <= q_cnt_n;
        end
    end

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Testbench for snake_input_ctrl with DEBOUNCE_CYCLES=4, BASE_TICK_CYCLES=64.
// A behavioural model (delay queue, run-length debounce, turn queue) tracks
// the expected outputs every cycle; table rows and hand sequences add
// scenario-level expectations. Honours SNAKE_TURN_QUEUE_EN when defined.
module tb_snake_input_ctrl;

    localparam int DEB  = 4;
    localparam int BASE = 64;
`ifdef SNAKE_TURN_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] BTN   = 4'd0;
    logic [2:0] SW    = 3'd0;
    logic       halt  = 1'b0;
    logic [1:0] dir;
    logic       move_tick;
    logic [3:0] btn_pulse;
    logic [1:0] pending_cnt;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 1'b0;
    int  tick_seen;
    int  pulse_seen;

    snake_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BASE_TICK_CYCLES(BASE),
        .RESET_DIR       (2'b11)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .BTN        (BTN),
        .SW         (SW),
        .halt       (halt),
        .dir        (dir),
        .move_tick  (move_tick),
        .btn_pulse  (btn_pulse),
        .pending_cnt(pending_cnt)
    );

    // Free-running 100 MHz style clock.
    always #5 clk = ~clk;

    // Behavioural reference model state.
    int         m_delay[$];
    int         m_stable[4];
    int         m_run[4];
    logic [3:0] m_pulse;
    logic [3:0] m_new_pulse;
    int         m_since;
    bit         m_tick;
    int         m_dir;
    int         m_pend[$];
    int         m_seen;
    int         m_cand;
    int         m_ref;
    int         m_bit;

    // Reference model advanced on every rising clock edge from the driven inputs.
    always @(posedge clk) begin
        if (reset) begin
            m_delay.delete();
            m_delay.push_back(0);
            m_delay.push_back(0);
            for (int i = 0; i < 4; i++) begin
                m_stable[i] = 0;
                m_run[i]    = 0;
            end
            m_pulse = 4'd0;
            m_since = 0;
            m_tick  = 1'b0;
            m_dir   = 3;
            m_pend.delete();
        end else begin
            if (halt) begin
                m_since = 0;
                m_tick  = 1'b0;
            end else if (m_since >= (BASE >> SW) - 1) begin
                m_since = 0;
                m_tick  = 1'b1;
            end else begin
                m_since = m_since + 1;
                m_tick  = 1'b0;
            end
            if (m_tick && m_pend.size() > 0) m_dir = m_pend.pop_front();

            if (!halt && m_pulse != 4'd0) begin
                m_cand = 0;
                for (int i = 3; i >= 0; i--) if (m_pulse[i]) m_cand = i;
                m_ref = (QUEUE && m_pend.size() > 0) ? m_pend[m_pend.size()-1] : m_dir;
                if ((m_cand >> 1) != (m_ref >> 1)) begin
                    if (QUEUE) begin
                        if (m_pend.size() < 2) m_pend.push_back(m_cand);
                    end else begin
                        m_pend.delete();
                        m_pend.push_back(m_cand);
                    end
                end
            end

            m_seen = m_delay.pop_front();
            m_delay.push_back(int'(BTN));
            m_new_pulse = 4'd0;
            for (int i = 0; i < 4; i++) begin
                m_bit = (m_seen >> i) & 1;
                if (m_bit != m_stable[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        m_stable[i] = m_bit;
                        m_run[i]    = 0;
                        if (m_bit == 1) m_new_pulse[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pulse = m_new_pulse;
        end
    end

    task automatic checkValue(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkOutput();
        n_checks++;
        if (dir === 2'(m_dir) && move_tick === m_tick && btn_pulse === m_pulse &&
            pending_cnt === 2'(m_pend.size())) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL model t=%0t: got dir=%b tick=%b pulse=%b pend=%0d, expected dir=%0d tick=%b pulse=%b pend=%0d",
                     $time, dir, move_tick, btn_pulse, pending_cnt, m_dir, m_tick, m_pulse, m_pend.size());
        end
    endtask

    task automatic applyStimulus(input logic [3:0] b, input logic [2:0] s, input logic h);
        BTN  = b;
        SW   = s;
        halt = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (chk_en) checkOutput();
        if (move_tick === 1'b1) tick_seen++;
        if (btn_pulse !== 4'd0) pulse_seen++;
    endtask

    task automatic doReset();
        applyStimulus(4'd0, 3'd0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic waitTick(input string name, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (move_tick !== 1'b1 && n < limit);
        if (move_tick !== 1'b1) begin
            n_checks++;
            $display("[TB] FAIL %s timeout: no move_tick within %0d cycles, expected one", name, limit);
        end
    endtask

    typedef struct {
        string      name;
        logic [3:0] btn;
        logic [2:0] sw;
        logic       halt;
        int         press;
        int         total;
        int         exp_dir;
        int         exp_pend;
        int         exp_ticks;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[7];
    int   n;
    int   hold;
    int   r;

    initial begin
        vecs[0] = '{"up_turn",       4'b0001, 3'd1, 1'b0, 10,  40, 0, 0,  1, 1};
        vecs[1] = '{"left_opposite", 4'b0100, 3'd1, 1'b0, 10, 100, 3, 0,  3, 1};
        vecs[2] = '{"down_glitch",   4'b0010, 3'd1, 1'b0,  2,  40, 3, 0,  1, 0};
        vecs[3] = '{"up_pending",    4'b0001, 3'd0, 1'b0, 10,  20, 3, 1,  0, 1};
        vecs[4] = '{"halt_press",    4'b0001, 3'd0, 1'b1, 10, 100, 3, 0,  0, 1};
        vecs[5] = '{"right_same",    4'b1000, 3'd6, 1'b0, 10,  10, 3, 0, 10, 1};
        vecs[6] = '{"down_on_tick",  4'b0010, 3'd6, 1'b0, 10,  12, 1, 0, 12, 1};

        step();
        step();
        chk_en = 1'b1;

        // Reset state.
        doReset();
        checkValue("reset dir", int'(dir), 3);
        checkValue("reset move_tick", int'(move_tick), 0);
        checkValue("reset btn_pulse", int'(btn_pulse), 0);
        checkValue("reset pending_cnt", int'(pending_cnt), 0);

        // Table-driven scenarios, each from a fresh reset.
        for (int v = 0; v < 7; v++) begin
            doReset();
            applyStimulus(vecs[v].btn, vecs[v].sw, vecs[v].halt);
            tick_seen  = 0;
            pulse_seen = 0;
            for (int c = 1; c <= vecs[v].total; c++) begin
                if (c == vecs[v].press + 1) BTN = 4'd0;
                step();
            end
            checkValue({vecs[v].name, " dir"}, int'(dir), vecs[v].exp_dir);
            checkValue({vecs[v].name, " pending"}, int'(pending_cnt), vecs[v].exp_pend);
            checkValue({vecs[v].name, " ticks"}, tick_seen, vecs[v].exp_ticks);
            checkValue({vecs[v].name, " pulses"}, pulse_seen, vecs[v].exp_pulses);
        end

        // Tick period with SW=1 is 32 cycles, single-cycle wide.
        doReset();
        applyStimulus(4'd0, 3'd1, 1'b0);
        waitTick("first_tick", 100, n);
        checkValue("first tick latency", n, 32);
        for (int k = 0; k < 3; k++) begin
            waitTick("period", 100, n);
            checkValue("tick period sw1", n, 32);
        end

        // Up then left within one period.
        doReset();
        applyStimulus(4'b0001, 3'd1, 1'b0);
        repeat (5) step();
        BTN = 4'd0;
        repeat (6) step();
        BTN = 4'b0100;
        repeat (5) step();
        BTN = 4'd0;
        repeat (4) step();
        checkValue("two_turns pending", int'(pending_cnt), QUEUE ? 2 : 1);
        waitTick("two_turns tick1", 50, n);
        checkValue("two_turns tick1 latency", n, 12);
        checkValue("two_turns dir tick1", int'(dir), 0);
        waitTick("two_turns tick2", 50, n);
        checkValue("two_turns tick2 latency", n, 32);
        checkValue("two_turns dir tick2", int'(dir), QUEUE ? 2 : 0);
        checkValue("two_turns pending end", int'(pending_cnt), 0);

        // Halt freezes the tick; release gives a full period first.
        doReset();
        applyStimulus(4'd0, 3'd0, 1'b1);
        tick_seen = 0;
        repeat (100) step();
        checkValue("halt ticks", tick_seen, 0);
        applyStimulus(4'd0, 3'd2, 1'b0);
        waitTick("halt_release", 50, n);
        checkValue("halt release latency", n, 16);

        // Reset mid-period with a tick due every cycle.
        doReset();
        applyStimulus(4'b0010, 3'd6, 1'b0);
        repeat (5) step();
        reset = 1'b1;
        step();
        checkValue("midreset move_tick", int'(move_tick), 0);
        checkValue("midreset dir", int'(dir), 3);
        checkValue("midreset pulse", int'(btn_pulse), 0);
        reset = 1'b0;

        // Randomized traffic against the model.
        doReset();
        hold = 0;
        SW   = 3'd4;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                r = int'($urandom_range(0, 9));
                if (r < 4) BTN = 4'd0;
                else if (r < 8) BTN = 4'(1 << $urandom_range(0, 3));
                else BTN = 4'($urandom_range(0, 15));
                hold = int'($urandom_range(1, 12));
            end else begin
                hold--;
            end
            if ($urandom_range(0, 199) == 0) SW = 3'($urandom_range(0, 6));
            if ($urandom_range(0, 149) == 0) halt = ~halt;
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
